if_stage: RTL

Instruction fetch stage, directly upstream of instruction decode. Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. Holds up to `FQ_DEPTH` fetched instructions so decode sees one instruction per cycle. Obeys the hazard-unit stall and redirects on taken branches/jumps resolved in execute, discarding stale in-flight responses.

---
 rtl/if_stage_pkg.sv | 29 ++
 rtl/if_stage_if.sv | 29 ++
 rtl/if_stage_fetch_queue.sv | 62 ++++++
 rtl/if_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types for the instruction fetch stage: decode-facing output record,
// fetch-queue entry, FSM state encoding and the canonical NOP.
package if_stage_pkg;

  localparam int          PC_W     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
  } if_stage_out_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } fq_entry_t;

  typedef enum logic [0:0] {
    ST_RESET = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  // Redirect targets are word addresses; the low two bits carry no meaning.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and memory (slave).
// A request transfers on a cycle where req_valid && req_ready; req_addr must not
// change while req_valid is waiting for req_ready. rsp_valid returns one word per
// accepted request, strictly in order, at least one cycle after acceptance.
interface if_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/if_stage_fetch_queue.sv
// Small synchronous FIFO of fetched {inst, pc} pairs feeding decode.
// Clear wins over push; pop and push may happen in the same cycle, even when full.
module if_stage_fetch_queue
  import if_stage_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(DEPTH + 1),
  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is reset so an empty queue still presents a defined head record.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{inst: NOP_INST, pc: RESET_PC};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches,
// buffers responses for decode and discards responses made stale by a redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = PC_W,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  if_stage_if.master            imem,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output if_stage_out_t         if_stage_out,
  output logic                  if_valid,
  output fetch_state_t          dbg_state
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] rsp_pc;
  logic [CW-1:0]         pending;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         fq_count;
  logic [CW:0]           in_use;
  logic                  fq_empty;
  fq_entry_t             fq_head;
  fq_entry_t             fq_push_data;
  logic                  credit_ok;
  logic                  pop;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  fq_push;

  // Credits cover both queued and in-flight words, so a push can never overflow.
  assign pop       = if_valid && !stall;
  assign in_use    = {1'b0, pending} + {1'b0, fq_count} - (CW + 1)'(pop);
  assign credit_ok = (in_use < (CW + 1)'(FQ_DEPTH));

  assign imem.req_addr = pc;
  assign req_fire      = imem.req_valid && imem.req_ready;
  assign rsp_fire      = imem.rsp_valid && (pending != '0);
  assign fq_push       = rsp_fire && !redirect_valid && (drop == '0);
  assign fq_push_data  = '{inst: imem.rsp_data, pc: rsp_pc};

  assign if_valid  = !fq_empty && !redirect_valid;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    imem.req_valid = 1'b0;
    unique case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: imem.req_valid = !redirect_valid && credit_ok;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // rsp_pc tracks the address of the next response that will actually be kept;
  // since requests are issued sequentially it only needs to step by 4 per push.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      rsp_pc  <= RESET_PC;
      pending <= '0;
      drop    <= '0;
    end else begin
      pending <= pending + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        pc     <= word_align(redirect_pc);
        rsp_pc <= word_align(redirect_pc);
        // Every outstanding request is now stale; one may be retiring this cycle.
        drop   <= pending - CW'(rsp_fire);
      end else begin
        if (req_fire) pc <= pc + DATA_WIDTH'(4);
        if (fq_push)  rsp_pc <= rsp_pc + DATA_WIDTH'(4);
        if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  if_stage_fetch_queue #(
    .DEPTH    (FQ_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (pop),
    .head      (fq_head),
    .count     (fq_count),
    .empty     (fq_empty)
  );

  always_comb begin
    if_stage_out.pc   = fq_head.pc;
    if_stage_out.pc4  = fq_head.pc + PC_W'(4);
    if_stage_out.inst = if_valid ? fq_head.inst : NOP_INST;
  end

  rsp_without_request: assert property (
    @(posedge clk) disable iff (rst) !(imem.rsp_valid && (pending == '0))
  );

endmodule
